// File: rtl/mips_muldiv_unit.sv
// ============================================================================
// mips_muldiv_unit : iterative MIPS HI/LO multiply/divide unit (radix-2)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // Multiply step: p holds {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, p_q[WIDTH-1:1]};

  // Divide step: p holds {partial remainder, dividend bits becoming quotient bits}.
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_trial    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, opnd_q});
  assign w_sub      = w_trial[WIDTH-1:0] - opnd_q;
  assign w_div_next = w_ge ? {w_sub, p_q[WIDTH-2:0], 1'b1}
                           : {w_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};

  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_neg_res;

  assign w_quo     = p_q[WIDTH-1:0];
  assign w_rem     = p_q[2*WIDTH-1:WIDTH];
  assign w_neg_res = neg_a_q ^ neg_b_q;
  assign w_prod    = w_neg_res ? (~p_q + 1'b1) : p_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d  = S_CALC;
          cnt_d    = CW'(WIDTH);
          is_div_d = op[1];
          neg_a_d  = w_a_neg;
          neg_b_d  = w_b_neg;
          bzero_d  = (b == '0);
          a_d      = a;
          p_d      = op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
          opnd_d   = op[1] ? w_b_mag : w_a_mag;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        p_d   = is_div_q ? w_div_next : w_mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        if (!is_div_q) begin
          {hi_d, lo_d} = w_prod;
        end else if (bzero_q) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = neg_a_q   ? (~w_rem + 1'b1) : w_rem;
          lo_d = w_neg_res ? (~w_quo + 1'b1) : w_quo;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A kill abandons the operation without touching architectural state.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
// ============================================================================
// tb_mips_muldiv_unit : scoreboard bench with arithmetic reference model
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due_edge;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int busy_run = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;
  logic         mdl_dbz = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: {dbz, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint      sa, sb, p, q, r;
    logic [63:0] up, uq, ur;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    model = '0;
    case (o)
      2'd0: begin
        p = sa * sb;
        model = {1'b0, p[63:0]};
      end
      2'd1: begin
        up = {32'd0, x} * {32'd0, y};
        model = {1'b0, up};
      end
      default: begin
        if (y == '0) begin
          model = {1'b1, x, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          model = {1'b0, r[31:0], q[31:0]};
        end else begin
          uq = {32'd0, x} / {32'd0, y};
          ur = {32'd0, x} % {32'd0, y};
          model = {1'b0, ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  // Call at posedge+1; start is sampled by the following edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_done);
    exp_t e;
    logic [2*W:0] r;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_done) begin
      r          = model(o, x, y);
      e.dbz      = r[2*W];
      e.hi       = r[2*W-1:W];
      e.lo       = r[W-1:0];
      e.due_edge = edge_cnt + W + 2;
      sbq.push_back(e);
      mdl_hi  = e.hi;
      mdl_lo  = e.lo;
      mdl_dbz = e.dbz;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_60_cycles");
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'h0000_0000;
      1:       pick = 32'hFFFF_FFFF;
      2:       pick = 32'h8000_0000;
      3:       pick = 32'($urandom_range(0, 20));
      default: pick = $urandom;
    endcase
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (busy === 1'b1) begin
      busy_run++;
    end else if (done !== 1'b1) begin
      busy_run = 0;
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done hi=%h lo=%h", hi, lo);
      end else begin
        e = sbq.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("done_latency_edge", 64'(edge_cnt), 64'(e.due_edge));
        chk("busy_cycles", 64'(busy_run), 64'(W + 1));
      end
      busy_run = 0;
    end
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    // Release and start in the same cycle; every op below is issued back-to-back in the done cycle.
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1);
    wait_done();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    wait_done();
    issue(2'd3, 32'd7, 32'd2, 1);
    wait_done();
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1);
    wait_done();
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done();
    issue(2'd2, 32'd5, 32'd0, 1);
    wait_done();
    issue(2'd0, 32'd2, 32'd3, 1);
    wait_done();

    // MTHI/MTLO in idle, including both strobes together.
    cycle();
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h0000_ABCD;
    cycle();
    lo_we = 1'b0;
    wdata = 32'h0000_1234;
    cycle();
    hi_we = 1'b0;
    mdl_hi = 32'h0000_1234;
    mdl_lo = 32'h0000_ABCD;
    chk("mthi_value", 64'(hi), 64'(mdl_hi));
    chk("mtlo_value", 64'(lo), 64'(mdl_lo));

    // MTLO coincident with an accepted start is dropped; stray starts and MTHI while busy are ignored.
    lo_we = 1'b1;
    wdata = 32'h0000_DEAD;
    issue(2'd0, 32'd5, 32'd6, 0);
    lo_we = 1'b0;
    chk("mtlo_with_start_dropped", 64'(lo), 64'(mdl_lo));
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd3;
      end
      if (i == 4) begin
        hi_we = 1'b1;
        wdata = 32'h0000_BEEF;
      end
      cycle();
      start = 1'b0;
      hi_we = 1'b0;
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'(mdl_hi));
    chk("flush_lo_kept", 64'(lo), 64'(mdl_lo));
    repeat (40) cycle();
    chk("flush_no_late_write_hi", 64'(hi), 64'(mdl_hi));

    // Flush and start together in idle: start ignored.
    start = 1'b1;
    flush = 1'b1;
    op    = 2'd0;
    a     = 32'd9;
    b     = 32'd9;
    cycle();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_ignored", 64'(busy), 64'd0);
    repeat (2) cycle();

    issue(2'd0, 32'd5, 32'd6, 1);
    wait_done();

    // Reset in the middle of a divide that follows a divide-by-zero.
    issue(2'd3, 32'd9, 32'd0, 1);
    wait_done();
    issue(2'd2, 32'd100, 32'd7, 0);
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    chk("midop_rst_busy", 64'(busy), 64'd0);
    chk("midop_rst_hi", 64'(hi), 64'd0);
    chk("midop_rst_lo", 64'(lo), 64'd0);
    chk("midop_rst_dbz", 64'(div_by_zero), 64'd0);
    mdl_hi  = '0;
    mdl_lo  = '0;
    mdl_dbz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) cycle();
    chk("post_rst_hi_hold", 64'(hi), 64'd0);

    // Randomized traffic with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1);
      wait_done();
      if ($urandom_range(0, 1) == 1) cycle();
    end

    repeat (3) cycle();
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and 8..64.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  rs operand (multiplicand/dividend).
REQ-007 SHALL have port b  input  WIDTH  rt operand (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  abandon the in-flight operation (pipeline kill).
REQ-009 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-010 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-011 SHALL have port wdata  input  WIDTH  MTHI/MTLO data.
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port div_by_zero  output  1  last completed DIV/DIVU had b==0.
REQ-015 SHALL have port hi  output  WIDTH  HI register.
REQ-016 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; busy=1 exactly in CALC and FIX.
REQ-018 In IDLE, start=1 SHALL latch op, a, b and enter CALC on that edge; start in CALC/FIX SHALL be ignored.
REQ-019 CALC SHALL run exactly WIDTH cycles, one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle, on operand magnitudes for signed ops.
REQ-020 FIX SHALL last one cycle, apply sign correction, and on exit write hi/lo, pulse done=1 for one cycle, return to IDLE.
REQ-021 Latency: done and new hi/lo SHALL be visible WIDTH+1 rising edges after the edge sampling start (33 at WIDTH=32); back-to-back start in the done cycle SHALL be accepted.
REQ-022 MULT/MULTU SHALL produce the full 2*WIDTH product, {hi,lo}, signed or unsigned per op.
REQ-023 DIV/DIVU SHALL give lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-024 DIV with a=most-negative, b=-1 SHALL give lo=most-negative, hi=0, no flag.
REQ-025 Divide with b==0 SHALL keep full latency, give hi=a, lo=all ones, div_by_zero=1.
REQ-026 div_by_zero SHALL update only when done pulses; cleared by any completion with b!=0 or any multiply.
REQ-027 flush=1 SHALL return FSM to IDLE on the next edge, hi/lo/div_by_zero unchanged, no done pulse; flush in IDLE has no effect; flush and start in the same IDLE cycle -> start ignored.
REQ-028 hi_we/lo_we in IDLE without start SHALL write wdata to hi/lo on that edge; both may write in the same cycle.
REQ-029 hi_we/lo_we while busy, or coincident with accepted start, SHALL be dropped.
REQ-030 Outputs SHALL be registered; hi/lo hold value except at REQ-020/REQ-028 writes.

Reset
REQ-031 rst=1 SHALL immediately, without clock, force IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, clearing internal counters.
REQ-032 rst asserted mid-operation SHALL discard it; no done pulse after rst release.
REQ-033 After rst deasserts, start SHALL be accepted on the first rising edge.

Verification (WIDTH=32)
REQ-034 MULT a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly 33 edges after start, busy high 32+1 cycles.
REQ-035 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 7/2 -> lo=3, hi=1.
REQ-036 DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIV a=5 b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1; following MULT 2*3 -> lo=6, div_by_zero=0.
REQ-038 MTHI 0x1234 then start MULT, flush at cycle 10 -> no done, hi=0x1234; restart completes normally; start pulses during busy ignored.
REQ-039 Assert rst at cycle 5 of DIV -> busy=0, hi=lo=0 asynchronously, no later done; new op after release correct.
